// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel input debouncer: channel FSM state
// encoding and its width.
package debounce_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_STABLE  = 2'd0;
    localparam state_t S_BOUNCE1 = 2'd1;
    localparam state_t S_BOUNCE2 = 2'd2;

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, polarity, bounce FSM, live-timeout
// timer, burst start position and optional bounce statistics (DEBOUNCE_STATS_EN).
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   POS_W      = 32,
    parameter int   TIMER_W    = 32,
    parameter logic INVERT_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sig_in,
    input  logic [POS_W-1:0]   pos_in,
    input  logic [TIMER_W-1:0] timeout,
    output logic               value,
    output logic               value_changed,
    output logic [POS_W-1:0]   change_pos,
    output logic [TIMER_W-1:0] max_bounce,
    output state_t             state
);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               value_q, value_d;
    logic               value_changed_q, value_changed_d;
    logic [POS_W-1:0]   change_pos_q, change_pos_d;
    logic [POS_W-1:0]   start_pos_q, start_pos_d;

    logic               sig;
    logic               differ;
    logic               expired;
    logic [TIMER_W-1:0] timer_inc;

    assign sig       = sync2_q ^ INVERT_BIT;
    assign differ    = (sig != value_q);
    assign expired   = (timer_q >= timeout);
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            state_q         <= S_STABLE;
            timer_q         <= '0;
            value_q         <= 1'b0;
            value_changed_q <= 1'b0;
            change_pos_q    <= '0;
            start_pos_q     <= '0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            timer_q         <= timer_d;
            value_q         <= value_d;
            value_changed_q <= value_changed_d;
            change_pos_q    <= change_pos_d;
            start_pos_q     <= start_pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_STABLE:  if (differ) state_d = S_BOUNCE1;
            S_BOUNCE1: begin
                if (!differ)      state_d = S_BOUNCE2;
                else if (expired) state_d = S_STABLE;
            end
            S_BOUNCE2: begin
                if (differ)       state_d = S_BOUNCE1;
                else if (expired) state_d = S_STABLE;
            end
            default:   state_d = S_STABLE;
        endcase
    end

    // Timer restarts on every segment change; start_pos only loads on leaving STABLE.
    always_comb begin
        sync1_d         = sig_in;
        sync2_d         = sync1_q;
        timer_d         = timer_q;
        value_d         = value_q;
        value_changed_d = 1'b0;
        change_pos_d    = change_pos_q;
        start_pos_d     = start_pos_q;
        case (state_q)
            S_STABLE: begin
                if (differ) begin
                    timer_d     = '0;
                    start_pos_d = pos_in;
                end
            end
            S_BOUNCE1: begin
                if (!differ) begin
                    timer_d = '0;
                end else if (expired) begin
                    value_d         = sig;
                    value_changed_d = 1'b1;
                    change_pos_d    = start_pos_q;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_BOUNCE2: begin
                if (differ) begin
                    timer_d = '0;
                end else if (!expired) begin
                    timer_d = timer_inc;
                end
            end
            default: timer_d = '0;
        endcase
    end

`ifdef DEBOUNCE_STATS_EN
    logic [TIMER_W-1:0] max_bounce_q, max_bounce_d;
    logic [TIMER_W-1:0] seg_max;

    assign seg_max = (timer_q > max_bounce_q) ? timer_q : max_bounce_q;

    always_ff @(posedge clk) begin
        if (reset) max_bounce_q <= '0;
        else       max_bounce_q <= max_bounce_d;
    end

    // A segment closes whenever the burst flips between BOUNCE1 and BOUNCE2.
    always_comb begin
        max_bounce_d = max_bounce_q;
        if (state_q == S_STABLE && differ)
            max_bounce_d = '0;
        else if ((state_q == S_BOUNCE1 && !differ) || (state_q == S_BOUNCE2 && differ))
            max_bounce_d = seg_max;
    end

    assign max_bounce = max_bounce_q;
`else
    assign max_bounce = '0;
`endif

    always_comb begin
        state         = state_q;
        value         = value_q;
        value_changed = value_changed_q;
        change_pos    = change_pos_q;
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel endstop debouncer top: per-channel debounce_chan instances, polarity,
// sticky change mask. Bounce statistics are built only with DEBOUNCE_STATS_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int              N_CH    = 4,
    parameter int              POS_W   = 32,
    parameter int              TIMER_W = 32,
    parameter logic [N_CH-1:0] INVERT  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           sig_in,
    input  logic [POS_W-1:0]          pos_in,
    input  logic [TIMER_W-1:0]        timeout,
    input  logic [N_CH-1:0]           clear_mask,
    output logic [N_CH-1:0]           value,
    output logic [N_CH-1:0]           value_changed,
    output logic [N_CH*POS_W-1:0]     change_pos,
    output logic [N_CH-1:0]           changed_mask,
    output logic                      any_changed,
    output logic [N_CH*TIMER_W-1:0]   max_bounce,
    output logic [N_CH*STATE_W-1:0]   state_dbg
);

    logic [N_CH-1:0] changed_mask_q, changed_mask_d;
    logic            any_changed_q, any_changed_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .POS_W      (POS_W),
            .TIMER_W    (TIMER_W),
            .INVERT_BIT (INVERT[i])
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .sig_in        (sig_in[i]),
            .pos_in        (pos_in),
            .timeout       (timeout),
            .value         (value[i]),
            .value_changed (value_changed[i]),
            .change_pos    (change_pos[i*POS_W +: POS_W]),
            .max_bounce    (max_bounce[i*TIMER_W +: TIMER_W]),
            .state         (state_dbg[i*STATE_W +: STATE_W])
        );
    end

    // Set beats clear when a strobe and a clear land in the same cycle.
    always_comb begin
        changed_mask_d = (changed_mask_q & ~clear_mask) | value_changed;
        any_changed_d  = |changed_mask_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            changed_mask_q <= '0;
            any_changed_q  <= 1'b0;
        end else begin
            changed_mask_q <= changed_mask_d;
            any_changed_q  <= any_changed_d;
        end
    end

    assign changed_mask = changed_mask_q;
    assign any_changed  = any_changed_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed plus randomized bench for debounce_multi against a run-length model
// of pin bursts; strobes are also matched through an expected queue.
module tb_debounce_multi;

    localparam int N_CH    = 4;
    localparam int POS_W   = 32;
    localparam int TIMER_W = 32;
    localparam logic [N_CH-1:0] INV = 4'b1000;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_CH-1:0]         sig_in;
    logic [POS_W-1:0]        pos_in;
    logic [TIMER_W-1:0]      timeout;
    logic [N_CH-1:0]         clear_mask;
    logic [N_CH-1:0]         value;
    logic [N_CH-1:0]         value_changed;
    logic [N_CH*POS_W-1:0]   change_pos;
    logic [N_CH-1:0]         changed_mask;
    logic                    any_changed;
    logic [N_CH*TIMER_W-1:0] max_bounce;
    logic [N_CH*2-1:0]       state_dbg;

    debounce_multi #(
        .N_CH(N_CH), .POS_W(POS_W), .TIMER_W(TIMER_W), .INVERT(INV)
    ) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .pos_in(pos_in),
        .timeout(timeout), .clear_mask(clear_mask), .value(value),
        .value_changed(value_changed), .change_pos(change_pos),
        .changed_mask(changed_mask), .any_changed(any_changed),
        .max_bounce(max_bounce), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // expected strobes: {channel, change_pos}
    logic [POS_W+1:0] exp_q[$];

    // model: pin pipeline, committed level, and the current burst as run lengths
    logic        m_p1[N_CH], m_p2[N_CH];
    logic        m_val[N_CH], m_vc[N_CH];
    logic [31:0] m_cpos[N_CH], m_start[N_CH];
    logic        m_inb[N_CH], m_dif[N_CH];
    int unsigned m_len[N_CH], m_mx[N_CH];
    logic [N_CH-1:0] m_mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_p1[c] = 0; m_p2[c] = 0; m_val[c] = 0; m_vc[c] = 0;
            m_cpos[c] = 0; m_start[c] = 0; m_inb[c] = 0; m_dif[c] = 0;
            m_len[c] = 0; m_mx[c] = 0;
        end
        m_mask = '0;
    endtask

    task automatic model_edge();
        logic s, differ;
        logic [N_CH-1:0] old_vc;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N_CH; c++) old_vc[c] = m_vc[c];
        m_mask = (m_mask & ~clear_mask) | old_vc;
        for (int c = 0; c < N_CH; c++) begin
            m_vc[c] = 0;
            s = m_p2[c] ^ INV[c];
            m_p2[c] = m_p1[c];
            m_p1[c] = sig_in[c];
            differ = (s != m_val[c]);
            if (!m_inb[c]) begin
                if (differ) begin
                    m_inb[c] = 1; m_dif[c] = 1; m_len[c] = 1;
                    m_start[c] = pos_in; m_mx[c] = 0;
                end
            end else if (differ != m_dif[c]) begin
                if (m_len[c] - 1 > m_mx[c]) m_mx[c] = m_len[c] - 1;
                m_dif[c] = differ;
                m_len[c] = 1;
            end else if (m_len[c] - 1 >= timeout) begin
                if (differ) begin
                    m_val[c] = s; m_vc[c] = 1; m_cpos[c] = m_start[c];
                    exp_q.push_back({c[1:0], m_start[c]});
                end
                m_inb[c] = 0;
            end else begin
                m_len[c]++;
            end
        end
    endtask

    task automatic compare_all();
        logic [POS_W+1:0] e;
        logic [1:0] st;
        logic [31:0] mb;
        for (int c = 0; c < N_CH; c++) begin
            st = !m_inb[c] ? 2'd0 : (m_dif[c] ? 2'd1 : 2'd2);
`ifdef DEBOUNCE_STATS_EN
            mb = m_mx[c];
`else
            mb = 0;
`endif
            chk($sformatf("value[%0d]", c), 64'(value[c]), 64'(m_val[c]));
            chk($sformatf("value_changed[%0d]", c), 64'(value_changed[c]), 64'(m_vc[c]));
            chk($sformatf("change_pos[%0d]", c), 64'(change_pos[c*POS_W +: POS_W]), 64'(m_cpos[c]));
            chk($sformatf("max_bounce[%0d]", c), 64'(max_bounce[c*TIMER_W +: TIMER_W]), 64'(mb));
            chk($sformatf("state[%0d]", c), 64'(state_dbg[c*2 +: 2]), 64'(st));
            if (value_changed[c]) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_strobe", 64'(c), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_strobe", 64'({c[1:0], change_pos[c*POS_W +: POS_W]}), 64'(e));
                end
            end
        end
        chk("changed_mask", 64'(changed_mask), 64'(m_mask));
        chk("any_changed", 64'(any_changed), 64'(|m_mask));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        exp_q.delete();
    endtask

    logic [31:0] saved_pos;
    int          strobes;
    int          seen;

    initial begin
        reset = 1; sig_in = '0; pos_in = '0; timeout = 5; clear_mask = '0;
        model_reset();
        do_reset();
        chk("reset_value", 64'(value), 64'h0);
        chk("reset_mask", 64'(changed_mask), 64'h0);

        // Test 4a: inverted channel with pin low rises shortly after reset
        for (int i = 0; i < 10; i++) begin pos_in = $urandom; cycle(); end
        chk("t4_inv_rise", 64'(value[3]), 64'h1);
        clear_mask = 4'hF; cycle(); clear_mask = '0; cycle();

        // Test 1: clean rise on ch0, T=5
        timeout = 5;
        sig_in[0] = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            pos_in = $urandom;
            if (e == 2) saved_pos = pos_in;
            cycle();
            if (e == 7) chk("t1_not_yet", 64'(value[0]), 64'h0);
        end
        chk("t1_value", 64'(value[0]), 64'h1);
        chk("t1_strobe", 64'(value_changed[0]), 64'h1);
        chk("t1_pos", 64'(change_pos[31:0]), 64'(saved_pos));
        cycle();
        chk("t1_mask", 64'(changed_mask), 64'h1);
        chk("t1_any", 64'(any_changed), 64'h1);

        // Test 2: bounce on ch1, T=10: high 4, low 3, then held high
        timeout = 10;
        strobes = 0;
        for (int e = 0; e < 30; e++) begin
            pos_in = $urandom;
            sig_in[1] = (e < 4 || e >= 7);
            if (e == 2) saved_pos = pos_in;
            cycle();
            if (value_changed[1]) strobes++;
        end
        chk("t2_strobes", 64'(strobes), 64'h1);
        chk("t2_value", 64'(value[1]), 64'h1);
        chk("t2_pos", 64'(change_pos[63:32]), 64'(saved_pos));
`ifdef DEBOUNCE_STATS_EN
        chk("t2_max_bounce", 64'(max_bounce[63:32]), 64'h3);
`else
        chk("t2_max_bounce", 64'(max_bounce[63:32]), 64'h0);
`endif

        // Test 3: 4-cycle glitch on ch2 is rejected
        strobes = 0;
        for (int e = 0; e < 25; e++) begin
            pos_in = $urandom;
            sig_in[2] = (e < 4);
            cycle();
            if (value_changed[2]) strobes++;
        end
        chk("t3_strobes", 64'(strobes), 64'h0);
        chk("t3_value", 64'(value[2]), 64'h0);
        chk("t3_state", 64'(state_dbg[5:4]), 64'h0);

        // Test 4b: inverted channel with pin held high never rises
        sig_in[3] = 1'b1;
        timeout = 5;
        do_reset();
        for (int i = 0; i < 20; i++) begin pos_in = $urandom; cycle(); end
        chk("t4_inv_held", 64'(value[3]), 64'h0);
        sig_in[3] = 1'b0;

        // Test 5: clear in the strobe cycle loses to set; a lone clear wins
        timeout = 3;
        sig_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin pos_in = $urandom; cycle(); end
        sig_in[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            pos_in = $urandom;
            cycle();
            if (value_changed[0]) seen = 1;
        end
        chk("t5_strobe_seen", 64'(seen), 64'h1);
        clear_mask = 4'b0001; cycle();
        chk("t5_set_wins", 64'(changed_mask[0]), 64'h1);
        cycle();
        chk("t5_clear", 64'(changed_mask[0]), 64'h0);
        clear_mask = '0;

        // Test 6: reset mid-burst, then timeout=0 commits at edge 3
        timeout = 20;
        sig_in = 4'b1110;
        for (int i = 0; i < 5; i++) begin pos_in = $urandom; cycle(); end
        reset = 1; cycle();
        chk("t6_value", 64'(value), 64'h0);
        chk("t6_strobe", 64'(value_changed), 64'h0);
        chk("t6_mask", 64'(changed_mask), 64'h0);
        chk("t6_any", 64'(any_changed), 64'h0);
        reset = 0; exp_q.delete();
        timeout = 0;
        sig_in = 4'b0001;
        for (int e = 0; e <= 3; e++) begin
            pos_in = $urandom;
            cycle();
            if (e == 2) chk("t6_early", 64'(value[0]), 64'h0);
        end
        chk("t6_commit", 64'(value[0]), 64'h1);
        chk("t6_commit_strobe", 64'(value_changed[0]), 64'h1);

        // Randomized phase: bouncy pins, live timeout changes, clears, resets
        for (int c = 0; c < 2500; c++) begin
            pos_in = $urandom;
            for (int ch = 0; ch < N_CH; ch++)
                if ($urandom_range(0, 7) == 0) sig_in[ch] = ~sig_in[ch];
            if ($urandom_range(0, 49) == 0) timeout = $urandom_range(0, 8);
            clear_mask = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            reset = ($urandom_range(0, 399) == 0);
            cycle();
            if (reset) exp_q.delete();
        end
        reset = 0; clear_mask = '0;
        for (int i = 0; i < 15; i++) cycle();
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
